alu_issue_sequencer: RTL and testbench

//  Hardware initiator for the ALU/instruction-memory datapath. Holds a small program of
//  {a, b, opcode} entries, issues them one at a time on the ALU operand ports and waits
//  out the ALU latency. Captures {carry_out, alu_out} per entry into a result buffer.

---
 rtl/alu_issue_sequencer_if.sv | 37 +++
 rtl/alu_issue_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_issue_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_sequencer_if.sv
// Bus between the ALU issue sequencer and its host: program load, run control,
// ALU operand/result path, status and the result-buffer read port.
interface alu_issue_sequencer_if #(
  parameter int AW = 3
) ();
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_a;
  logic [7:0]    prog_b;
  logic [2:0]    prog_op;
  logic [AW:0]   prog_len;
  logic          start;
  logic [7:0]    a;
  logic [7:0]    b;
  logic [2:0]    opcode;
  logic [7:0]    alu_out;
  logic          carry_out;
  logic          busy;
  logic          done;
  logic [AW:0]   res_count;
  logic [AW-1:0] rd_addr;
  logic [8:0]    rd_data;

  // Host side: loads programs, starts runs, hosts the ALU and reads results.
  modport master (
    output prog_we, prog_addr, prog_a, prog_b, prog_op, prog_len, start,
    output alu_out, carry_out, rd_addr,
    input  a, b, opcode, busy, done, res_count, rd_data
  );

  // Sequencer side.
  modport slave (
    input  prog_we, prog_addr, prog_a, prog_b, prog_op, prog_len, start,
    input  alu_out, carry_out, rd_addr,
    output a, b, opcode, busy, done, res_count, rd_data
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Self-running ALU issuer: steps through a stored {a, b, opcode} program, waits out
// the ALU latency per entry and captures {carry_out, alu_out} into a result buffer.
module alu_issue_sequencer #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int ALU_LAT = 1
) (
  input logic                  clk,
  input logic                  reset,
  alu_issue_sequencer_if.slave bus
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } entry_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          w_busy;
  logic          w_done;
  logic          w_last;
  logic [AW:0]   w_len_clamped;

  entry_t        r_prog [DEPTH];
  logic [8:0]    r_res  [DEPTH];
  logic [AW:0]   r_len;
  logic [AW-1:0] r_idx;
  logic [CW-1:0] r_wait_cnt;
  logic [AW:0]   r_res_count;
  logic [7:0]    r_a;
  logic [7:0]    r_b;
  logic [2:0]    r_op;
  logic [8:0]    r_rd_data;

  assign w_len_clamped = (bus.prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.prog_len;
  assign w_last        = (({1'b0, r_idx} + (AW+1)'(1)) == r_len);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next_state = (w_len_clamped == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE:   w_next_state = S_WAIT;
      S_WAIT:    if (r_wait_cnt == '0) w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = w_last ? S_DONE : S_ISSUE;
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: program and result memories have no reset; captured results survive an abort.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !w_busy)
      r_prog[bus.prog_addr] <= '{a: bus.prog_a, b: bus.prog_b, op: bus.prog_op};
    if (!reset && r_state == S_CAPTURE)
      r_res[r_idx] <= {bus.carry_out, bus.alu_out};
  end

  // Registered read: a capture to the same entry becomes visible one cycle later.
  always_ff @(posedge clk) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= r_res[bus.rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_wait_cnt  <= '0;
      r_res_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_len       <= w_len_clamped;
            r_idx       <= '0;
            r_res_count <= '0;
          end
        end
        S_ISSUE: begin
          r_a        <= r_prog[r_idx].a;
          r_b        <= r_prog[r_idx].b;
          r_op       <= r_prog[r_idx].op;
          r_wait_cnt <= CW'(ALU_LAT - 1);
        end
        S_WAIT: begin
          if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - 1'b1;
        end
        S_CAPTURE: begin
          r_res_count <= r_res_count + 1'b1;
          r_idx       <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.opcode    = r_op;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.res_count = r_res_count;
  assign bus.rd_data   = r_rd_data;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer: ALU_LAT=1 and ALU_LAT=3 instances, each
// driven by a behavioural ALU model with the matching latency.
module tb_alu_issue_sequencer;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [8:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   done_cnt1;
  logic [8:0] p1;
  logic [8:0] p3 [3];

  alu_issue_sequencer_if #(.AW(3)) bus1 ();
  alu_issue_sequencer_if #(.AW(3)) bus3 ();

  alu_issue_sequencer #(.DEPTH(8), .AW(3), .ALU_LAT(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  alu_issue_sequencer #(.DEPTH(8), .AW(3), .ALU_LAT(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    logic [15:0] p;
    case (op)
      3'b000: return {1'b0, a} + {1'b0, b};
      3'b001: return {a < b, a - b};
      3'b010: return {1'b0, a & b};
      3'b011: return {1'b0, a | b};
      3'b100: return {1'b0, a ^ b};
      3'b101: begin
        p = {8'd0, a} * {8'd0, b};
        return {|p[15:8], p[7:0]};
      end
      3'b110: return (b == 8'd0) ? 9'h1FF : {1'b0, a / b};
      default: return {a == b, 7'd0, a > b};
    endcase
  endfunction

  always @(posedge clk) p1 <= alu_f(bus1.a, bus1.b, bus1.opcode);
  assign bus1.carry_out = p1[8];
  assign bus1.alu_out   = p1[7:0];

  always @(posedge clk) begin
    p3[0] <= alu_f(bus3.a, bus3.b, bus3.opcode);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus3.carry_out = p3[2][8];
  assign bus3.alu_out   = p3[2][7:0];

  always @(negedge clk) if (bus1.done) done_cnt1++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic prog_write(input bit sel, input int addr, input logic [7:0] a,
                            input logic [7:0] b, input logic [2:0] op);
    if (!sel) begin
      bus1.prog_we = 1'b1; bus1.prog_addr = 3'(addr);
      bus1.prog_a = a; bus1.prog_b = b; bus1.prog_op = op;
    end else begin
      bus3.prog_we = 1'b1; bus3.prog_addr = 3'(addr);
      bus3.prog_a = a; bus3.prog_b = b; bus3.prog_op = op;
    end
    @(posedge clk); #1;
    bus1.prog_we = 1'b0;
    bus3.prog_we = 1'b0;
  endtask

  task automatic read_res(input bit sel, input int addr, output logic [8:0] d);
    if (!sel) bus1.rd_addr = 3'(addr);
    else      bus3.rd_addr = 3'(addr);
    @(posedge clk); #1;
    d = sel ? bus3.rd_data : bus1.rd_data;
  endtask

  // Starts a run on the ALU_LAT=1 instance (start taken at the next edge, cycle 0)
  // and checks the cycle done appears in; optionally disturbs it at poke_cyc.
  task automatic run1(input string tag, input int len, input int exp_cyc, input int poke_cyc);
    int c;
    int d0;
    d0 = done_cnt1;
    bus1.prog_len = 4'(len);
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    bus1.prog_we = 1'b0;
    c = 1;
    while (!bus1.done && c < 200) begin
      if (c == poke_cyc) begin
        bus1.start = 1'b1; bus1.prog_len = 4'd1;
        bus1.prog_we = 1'b1; bus1.prog_addr = 3'd6;
        bus1.prog_a = 8'd50; bus1.prog_b = 8'd50; bus1.prog_op = 3'b000;
      end
      @(posedge clk); #1;
      c++;
      bus1.start = 1'b0;
      bus1.prog_we = 1'b0;
    end
    check({tag, " done cycle"}, 32'(c), 32'(exp_cyc));
    check({tag, " busy with done"}, 32'(bus1.busy), 32'd1);
    @(posedge clk); #1;
    check({tag, " idle after done"}, 32'({bus1.busy, bus1.done}), 32'd0);
    check({tag, " single done pulse"}, 32'(done_cnt1 - d0), 32'd1);
  endtask

  vec_t tab_a [7];
  vec_t tab_b [8];

  initial begin
    logic [8:0] d;
    int c;
    int cnt5;

    tab_a[0] = '{8'd5, 8'd3, 3'b000, 9'h008};
    tab_a[1] = '{8'd5, 8'd3, 3'b001, 9'h002};
    tab_a[2] = '{8'd5, 8'd3, 3'b010, 9'h001};
    tab_a[3] = '{8'd5, 8'd3, 3'b011, 9'h007};
    tab_a[4] = '{8'd5, 8'd3, 3'b100, 9'h006};
    tab_a[5] = '{8'd5, 8'd3, 3'b101, 9'h00F};
    tab_a[6] = '{8'd5, 8'd3, 3'b110, 9'h001};

    tab_b[0] = '{8'd200, 8'd100, 3'b000, 9'h12C};
    tab_b[1] = '{8'd3,   8'd5,   3'b001, 9'h1FE};
    tab_b[2] = '{8'hF0,  8'h3C,  3'b010, 9'h030};
    tab_b[3] = '{8'hF0,  8'h0F,  3'b011, 9'h0FF};
    tab_b[4] = '{8'hAA,  8'hFF,  3'b100, 9'h055};
    tab_b[5] = '{8'd16,  8'd32,  3'b101, 9'h100};
    tab_b[6] = '{8'd200, 8'd7,   3'b110, 9'h01C};
    tab_b[7] = '{8'd9,   8'd9,   3'b111, 9'h100};

    checks = 0; errors = 0; done_cnt1 = 0;
    bus1.prog_we = 1'b0; bus1.prog_addr = '0; bus1.prog_a = '0; bus1.prog_b = '0;
    bus1.prog_op = '0; bus1.prog_len = '0; bus1.start = 1'b0; bus1.rd_addr = '0;
    bus3.prog_we = 1'b0; bus3.prog_addr = '0; bus3.prog_a = '0; bus3.prog_b = '0;
    bus3.prog_op = '0; bus3.prog_len = '0; bus3.start = 1'b0; bus3.rd_addr = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("reset a",         32'(bus1.a),         32'd0);
    check("reset b",         32'(bus1.b),         32'd0);
    check("reset opcode",    32'(bus1.opcode),    32'd0);
    check("reset busy",      32'(bus1.busy),      32'd0);
    check("reset done",      32'(bus1.done),      32'd0);
    check("reset res_count", 32'(bus1.res_count), 32'd0);
    check("reset rd_data",   32'(bus1.rd_data),   32'd0);

    // Single entry, written in the same cycle as the accepted start.
    prog_write(1'b0, 0, 8'd1, 8'd1, 3'b000);
    bus1.prog_we = 1'b1; bus1.prog_addr = 3'd0;
    bus1.prog_a = 8'd5; bus1.prog_b = 8'd3; bus1.prog_op = 3'b000;
    run1("len1", 1, 4, -1);
    check("len1 operands", 32'({bus1.a, bus1.b, bus1.opcode}), 32'({8'd5, 8'd3, 3'b000}));
    check("len1 res_count", 32'(bus1.res_count), 32'd1);
    read_res(1'b0, 0, d);
    check("len1 res0", 32'(d), 32'h008);

    for (int i = 0; i < 7; i++) prog_write(1'b0, i, tab_a[i].a, tab_a[i].b, tab_a[i].op);
    run1("len7", 7, 22, -1);
    check("len7 res_count", 32'(bus1.res_count), 32'd7);
    for (int i = 0; i < 7; i++) begin
      read_res(1'b0, i, d);
      check($sformatf("len7 res%0d", i), 32'(d), 32'(tab_a[i].exp));
    end

    // Start plus a program write issued during entry 2 must both be ignored.
    run1("restart", 7, 22, 7);
    check("restart res_count", 32'(bus1.res_count), 32'd7);
    read_res(1'b0, 6, d);
    check("restart res6", 32'(d), 32'(tab_a[6].exp));

    run1("len0", 0, 1, -1);
    check("len0 res_count", 32'(bus1.res_count), 32'd0);
    check("len0 operands", 32'({bus1.a, bus1.b, bus1.opcode}), 32'({8'd5, 8'd3, 3'b110}));

    // Abort with reset during the WAIT of entry 3 (cycle 11).
    for (int i = 0; i < 8; i++) prog_write(1'b0, i, tab_b[i].a, tab_b[i].b, tab_b[i].op);
    bus1.prog_len = 4'd8; bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    c = 1;
    while (c < 11) begin
      @(posedge clk); #1;
      c++;
    end
    check("abort busy before reset", 32'(bus1.busy), 32'd1);
    check("abort count before reset", 32'(bus1.res_count), 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy", 32'(bus1.busy), 32'd0);
    check("abort operands", 32'({bus1.a, bus1.b, bus1.opcode}), 32'd0);
    check("abort res_count", 32'(bus1.res_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      read_res(1'b0, i, d);
      check($sformatf("abort res%0d", i), 32'(d), 32'((i < 3) ? tab_b[i].exp : tab_a[3].exp));
    end

    // prog_len above DEPTH runs all eight entries.
    run1("clamp", 15, 25, -1);
    check("clamp res_count", 32'(bus1.res_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      read_res(1'b0, i, d);
      check($sformatf("clamp res%0d", i), 32'(d), 32'(tab_b[i].exp));
    end

    // ALU_LAT=3 instance: five cycles per entry.
    prog_write(1'b1, 0, 8'd5, 8'd3, 3'b000);
    prog_write(1'b1, 1, 8'd9, 8'd4, 3'b001);
    bus3.prog_len = 4'd2; bus3.start = 1'b1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
    c = 1; cnt5 = 0;
    while (!bus3.done && c < 200) begin
      if (bus3.a == 8'd5 && bus3.b == 8'd3) cnt5++;
      @(posedge clk); #1;
      c++;
    end
    check("lat3 done cycle", 32'(c), 32'd11);
    check("lat3 entry0 stable cycles", 32'(cnt5), 32'd5);
    check("lat3 res_count", 32'(bus3.res_count), 32'd2);
    check("lat3 operands", 32'({bus3.a, bus3.b, bus3.opcode}), 32'({8'd9, 8'd4, 3'b001}));
    read_res(1'b1, 0, d);
    check("lat3 res0", 32'(d), 32'h008);
    read_res(1'b1, 1, d);
    check("lat3 res1", 32'(d), 32'h005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
